// File: rtl/msg_scroller.sv
// Scrolling message driver for a multiplexed, active-low 7-segment display.
// Symbols live in a small write-port buffer and are scrolled left or right by a run/idle FSM.
module msg_scroller #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_MAX     = 16,
  parameter int SCROLL_DIV  = 100_000_000,
  parameter int REFRESH_DIV = 250_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_MAX)-1:0] wr_addr,
  input  logic [4:0]                 wr_data,
  input  logic [$clog2(MSG_MAX):0]   msg_len,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       dir,
  input  logic                       one_shot,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
  output logic [$clog2(MSG_MAX)-1:0] pos,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(MSG_MAX);
  localparam int LW = AW + 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SCROLL_DIV + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int IW = LW + DW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         pos_q, pos_d;
  logic [AW-1:0]         start_pos_q, start_pos_d;
  logic [AW-1:0]         step_pos;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  done_q, done_d;
  logic [LW-1:0]         len;
  logic                  tick;
  logic [4:0]            sym;
  logic [4:0]            mem_q [MSG_MAX];

  // Buffer index for digit k: (p + NUM_DIGITS-1-k) mod len, by bounded repeated subtraction.
  function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] p,
                                             input logic [DW-1:0] k,
                                             input logic [LW-1:0] l);
    logic [IW-1:0] s;
    s = IW'(p) + IW'(NUM_DIGITS - 1) - IW'(k);
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      if (s >= IW'(l)) s = s - IW'(l);
    end
    return AW'(s);
  endfunction

  function automatic logic [6:0] decode(input logic [4:0] s);
    logic [6:0] lit;
    case (s)
      5'd0:    lit = 7'h3F;
      5'd1:    lit = 7'h06;
      5'd2:    lit = 7'h5B;
      5'd3:    lit = 7'h4F;
      5'd4:    lit = 7'h66;
      5'd5:    lit = 7'h6D;
      5'd6:    lit = 7'h7D;
      5'd7:    lit = 7'h07;
      5'd8:    lit = 7'h7F;
      5'd9:    lit = 7'h6F;
      5'd10:   lit = 7'h77;
      5'd11:   lit = 7'h7C;
      5'd12:   lit = 7'h39;
      5'd13:   lit = 7'h5E;
      5'd14:   lit = 7'h79;
      5'd15:   lit = 7'h71;
      5'd17:   lit = 7'h40;
      default: lit = 7'h00;
    endcase
    return ~lit;
  endfunction

  always_comb begin
    len = (msg_len > LW'(MSG_MAX)) ? LW'(MSG_MAX) : msg_len;
    if (dir) step_pos = (pos_q == '0) ? AW'(len - LW'(1)) : pos_q - AW'(1);
    else     step_pos = (LW'(pos_q) + LW'(1) >= len) ? '0 : pos_q + AW'(1);
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    start_pos_d = start_pos_q;
    scnt_d      = scnt_q;
    done_d      = 1'b0;
    tick        = (state_q == RUN) && (scnt_q == SW'(SCROLL_DIV - 1));

    case (state_q)
      IDLE: begin
        scnt_d = '0;
        if (start && !stop) begin
          state_d     = RUN;
          start_pos_d = pos_q;
        end
      end
      RUN: begin
        scnt_d = tick ? '0 : scnt_q + SW'(1);
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A shrunken message takes priority over a scroll step; len=0 always lands here.
    if (len <= LW'(pos_q)) begin
      pos_d = '0;
    end else if (tick) begin
      pos_d = step_pos;
      if (one_shot && !stop && (step_pos == start_pos_q)) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      dig_d  = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
    end else begin
      rcnt_d = rcnt_q + RW'(1);
      dig_d  = dig_q;
    end
    sym   = mem_q[wrap_idx(pos_q, dig_q, len)];
    seg_d = (len == '0) ? 7'h7F : decode(sym);
    an_d  = ~(NUM_DIGITS'(1) << dig_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      start_pos_q <= '0;
      scnt_q      <= '0;
      rcnt_q      <= '0;
      dig_q       <= '0;
      seg_q       <= 7'h7F;
      an_q        <= ~NUM_DIGITS'(1);
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      start_pos_q <= start_pos_d;
      scnt_q      <= scnt_d;
      rcnt_q      <= rcnt_d;
      dig_q       <= dig_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      done_q      <= done_d;
    end
  end

  // Message contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign pos  = pos_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
endmodule

// File: tb/tb_msg_scroller.sv
// Bench for msg_scroller: directed scenarios plus random traffic, checked every cycle
// against an arithmetic reference model of buffer, scroll position and refresh timing.
module tb_msg_scroller;
  localparam int ND = 4;
  localparam int MM = 8;
  localparam int SD = 8;
  localparam int RD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [3:0] msg_len;
  logic       start, stop, dir, one_shot;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] pos;
  logic       busy, done;

  always #5 clk = ~clk;

  msg_scroller #(.NUM_DIGITS(ND), .MSG_MAX(MM), .SCROLL_DIV(SD), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .stop(stop), .dir(dir), .one_shot(one_shot),
    .seg(seg), .an(an), .pos(pos), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] glyph(input int c);
    logic [6:0] lit;
    case (c)
      0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
      4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
      8: lit = 7'h7F;  9: lit = 7'h6F; 10: lit = 7'h77; 11: lit = 7'h7C;
      12: lit = 7'h39; 13: lit = 7'h5E; 14: lit = 7'h79; 15: lit = 7'h71;
      17: lit = 7'h40;
      default: lit = 7'h00;
    endcase
    return ~lit;
  endfunction

  // Reference model: state after each clock edge, from the values seen before it.
  int         m_buf[MM];
  int         m_pos = 0, m_start_pos = 0, m_rc = 0, m_ncyc = 0;
  bit         m_run = 0;
  bit         e_done = 0;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_an = 4'b1110;

  always @(posedge clk) begin
    int len, dg, npos;
    bit tick;
    if (rst) begin
      m_pos = 0; m_run = 0; m_rc = 0; m_ncyc = 0;
      e_seg = 7'h7F; e_an = 4'b1110; e_done = 0;
    end else begin
      len   = (int'(msg_len) > MM) ? MM : int'(msg_len);
      dg    = (m_ncyc / RD) % ND;
      e_an  = ~(4'b0001 << dg);
      e_seg = (len == 0) ? 7'h7F : glyph(m_buf[(m_pos + ND - 1 - dg) % len]);
      m_ncyc++;
      tick   = m_run && (((m_rc + 1) % SD) == 0);
      e_done = 0;
      npos   = m_pos;
      if (len <= m_pos) npos = 0;
      else if (tick) begin
        npos = dir ? (m_pos + len - 1) % len : (m_pos + 1) % len;
        if (one_shot && !stop && npos == m_start_pos) e_done = 1;
      end
      if (m_run) begin
        m_rc++;
        if (stop || e_done) m_run = 0;
      end else if (start && !stop) begin
        m_run = 1; m_rc = 0; m_start_pos = m_pos;
      end
      m_pos = npos;
    end
    if (wr_en) m_buf[wr_addr] = int'(wr_data);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        check_eq("rst_pos", 32'(pos), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_an", 32'(an), 32'hE);
        check_eq("rst_seg", 32'(seg), 32'h7F);
      end else begin
        check_eq("mdl_pos", 32'(pos), 32'(m_pos));
        check_eq("mdl_busy", 32'(busy), 32'(m_run));
        check_eq("mdl_done", 32'(done), 32'(e_done));
        check_eq("mdl_an", 32'(an), 32'(e_an));
        check_eq("mdl_seg", 32'(seg), 32'(e_seg));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1; wr_addr = 3'(a); wr_data = 5'(d);
    step(1);
    wr_en = 0;
  endtask

  task automatic wait_pos_change(input string tag);
    logic [2:0] old;
    bit seen;
    old  = pos;
    seen = 0;
    for (int i = 0; i < 3 * SD && !seen; i++) begin
      step(1);
      if (pos != old) seen = 1;
    end
    check_eq({tag, "_moved"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * ND * RD && !seen; i++) begin
      step(1);
      if (an == target) seen = 1;
    end
    check_eq({tag, "_found"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_pos_is(input int p, input string tag);
    for (int i = 0; i < 8 * SD && int'(pos) != p; i++) step(1);
    check_eq(tag, 32'(pos), 32'(p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s2_exp[6] = '{1, 2, 3, 4, 0, 1};
    int s3_exp[5] = '{4, 3, 2, 1, 0};
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; msg_len = 0;
    start = 0; stop = 0; dir = 0; one_shot = 0;
    step(1);
    chk_en = 1;
    for (int a = 0; a < MM; a++) wr(a, 16);
    check_eq("reset_pos", 32'(pos), 32'd0);
    check_eq("reset_an", 32'(an), 32'hE);
    check_eq("reset_seg", 32'(seg), 32'h7F);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    rst = 0;

    // Scenario 1: idle display of 1..5
    msg_len = 5;
    for (int a = 0; a < 5; a++) wr(a, a + 1);
    step(1);
    check_eq("s1_pos", 32'(pos), 32'd0);
    wait_an(4'b0111, "s1_an3");
    check_eq("s1_dig3", 32'(seg), 32'h79);
    wait_an(4'b1110, "s1_an0");
    check_eq("s1_dig0", 32'(seg), 32'h19);

    // Scenario 2: looping left scroll
    dir = 0; one_shot = 0; start = 1;
    step(1);
    start = 0;
    check_eq("s2_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      wait_pos_change("s2");
      check_eq("s2_pos", 32'(pos), 32'(s2_exp[i]));
    end
    wait_an(4'b0111, "s2_an3");
    check_eq("s2_left", 32'(seg), 32'h24);
    stop = 1;
    step(1);
    stop = 0;
    check_eq("s2_stop", 32'(busy), 32'd0);

    // Scenario 3: shrink to clear pos, then one-shot right scroll
    msg_len = 1;
    step(1);
    check_eq("s3_clear", 32'(pos), 32'd0);
    msg_len = 5; dir = 1; one_shot = 1; start = 1;
    step(1);
    start = 0;
    for (int i = 0; i < 5; i++) begin
      wait_pos_change("s3");
      check_eq("s3_pos", 32'(pos), 32'(s3_exp[i]));
    end
    check_eq("s3_done", 32'(done), 32'd1);
    check_eq("s3_busy", 32'(busy), 32'd0);
    step(1);
    check_eq("s3_done_pulse", 32'(done), 32'd0);

    // Scenario 4: short message repeats, empty message blanks
    dir = 0; one_shot = 0;
    wr(0, 10);
    wr(1, 11);
    msg_len = 2;
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_eq("s4_ab", 32'(seg), (an == 4'b0111 || an == 4'b1101) ? 32'h08 : 32'h03);
    end
    msg_len = 0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_eq("s4_blank", 32'(seg), 32'h7F);
    end

    // Scenario 5: shrink below pos while running; start+stop together
    wr(0, 1);
    wr(1, 2);
    msg_len = 5; start = 1;
    step(1);
    start = 0;
    wait_pos_is(4, "s5_reach4");
    msg_len = 3;
    step(1);
    check_eq("s5_clear", 32'(pos), 32'd0);
    msg_len = 5; stop = 1;
    step(1);
    stop = 0;
    check_eq("s5_stopped", 32'(busy), 32'd0);
    start = 1; stop = 1;
    step(1);
    start = 0; stop = 0;
    check_eq("s5_start_stop", 32'(busy), 32'd0);

    // Scenario 6: reset mid-run keeps the buffer
    start = 1;
    step(1);
    start = 0;
    wait_pos_is(3, "s6_reach3");
    rst = 1;
    #1;
    check_eq("s6_pos", 32'(pos), 32'd0);
    check_eq("s6_busy", 32'(busy), 32'd0);
    check_eq("s6_done", 32'(done), 32'd0);
    step(2);
    rst = 0;
    step(1);
    wait_an(4'b0111, "s6_an3");
    check_eq("s6_dig3", 32'(seg), 32'h79);
    wait_an(4'b1011, "s6_an2");
    check_eq("s6_dig2", 32'(seg), 32'h24);
    wait_an(4'b1101, "s6_an1");
    check_eq("s6_dig1", 32'(seg), 32'h30);
    wait_an(4'b1110, "s6_an0");
    check_eq("s6_dig0", 32'(seg), 32'h19);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      wr_en   = ($urandom % 4) == 0;
      wr_addr = 3'($urandom % MM);
      wr_data = 5'($urandom % 32);
      if ($urandom % 40 == 0) msg_len = 4'($urandom % 16);
      start = ($urandom % 20) == 0;
      stop  = ($urandom % 70) == 0;
      if ($urandom % 50 == 0) dir = 1'($urandom % 2);
      if ($urandom % 50 == 0) one_shot = 1'($urandom % 2);
      rst = ($urandom % 300) == 0;
      step(1);
    end
    rst = 0; wr_en = 0; start = 0; stop = 0;
    step(2);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/msg_scroller.md
MSG_SCROLLER -- requirements
Module: msg_scroller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits.
REQ-002 SHALL have parameter MSG_MAX, default 16: message buffer depth in symbols, a power of two, >= NUM_DIGITS.
REQ-003 SHALL have parameter SCROLL_DIV, default 100_000_000: clk cycles per scroll step.
REQ-004 SHALL have parameter REFRESH_DIV, default 250_000: clk cycles per digit refresh slot.
REQ-005 clk  in  1  system clock; all logic is single-domain; no derived clocks.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 wr_en  in  1  write one symbol into the buffer this cycle.
REQ-008 wr_addr  in  clog2(MSG_MAX)  buffer write address.
REQ-009 wr_data  in  5  symbol code.
REQ-010 msg_len  in  clog2(MSG_MAX)+1  active message length, 0..MSG_MAX.
REQ-011 start  in  1  one-cycle pulse that begins scrolling.
REQ-012 stop  in  1  one-cycle pulse that halts scrolling.
REQ-013 dir  in  1  0 = scroll left (pos increments), 1 = scroll right (pos decrements).
REQ-014 one_shot  in  1  1 = stop after one full pass; 0 = loop forever.
REQ-015 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-016 an  out  NUM_DIGITS  digit enables, active-low, one-cold.
REQ-017 pos  out  clog2(MSG_MAX)  current scroll offset.
REQ-018 busy  out  1  high in RUN state.
REQ-019 done  out  1  one-cycle pulse at end of a one_shot pass.

Function
REQ-020 The buffer SHALL be MSG_MAX x 5 bits, written synchronously on wr_en in any state; the written symbol SHALL be visible from the next refresh slot.
REQ-021 Symbol decode: codes 0-15 SHALL display hex 0-F, 16 SHALL be blank, 17 SHALL be dash (g only), 18-31 SHALL be blank.
REQ-022 The FSM SHALL have states IDLE and RUN: start moves IDLE->RUN; stop moves RUN->IDLE; stop wins when it coincides with start; start in RUN is ignored.
REQ-023 The scroll counter SHALL count only in RUN, clear on entry to RUN, and issue a step tick when it reaches SCROLL_DIV-1, then wrap to 0.
REQ-024 On a tick, pos SHALL become (pos+1) mod msg_len when dir=0, or (pos-1+msg_len) mod msg_len when dir=1.
REQ-025 one_shot pass: the pass SHALL end on the tick that returns pos to the value it held at RUN entry; that tick SHALL assert done for one cycle and move the FSM to IDLE.
REQ-026 The refresh counter SHALL run in all states and advance the digit index 0..NUM_DIGITS-1 every REFRESH_DIV cycles, wrapping to 0.
REQ-027 Digit k (k=0 rightmost) SHALL show buf[(pos + NUM_DIGITS-1-k) mod msg_len], so the leftmost digit shows buf[pos].
REQ-028 When msg_len < NUM_DIGITS, the index SHALL still wrap mod msg_len, so the message repeats across the digits.
REQ-029 When msg_len = 0, all digits SHALL be blank, ticks SHALL not change pos, and done SHALL never assert.
REQ-030 When a new msg_len is not above pos, pos SHALL clear to 0 in the next cycle.
REQ-031 msg_len > MSG_MAX SHALL be treated as MSG_MAX.
REQ-032 In IDLE, the display SHALL keep refreshing at the frozen pos.
REQ-033 seg and an SHALL be registered and change together, from the same digit index.

Reset
REQ-034 While rst is asserted:
- state = IDLE; pos = 0; both counters = 0; digit index = 0.
- an = all-ones except bit 0 low; seg = 7'h7F; busy = 0; done = 0.
- Buffer contents are preserved and not cleared.
REQ-035 rst asserted mid-RUN SHALL abort the pass immediately with no done pulse.

Verification
REQ-036 Common bench setup: NUM_DIGITS=4, MSG_MAX=8, SCROLL_DIV=8, REFRESH_DIV=2.
REQ-037 Scenario 1: write 1,2,3,4,5 at addresses 0-4, msg_len=5, idle -> an cycles 1110,1101,1011,0111 every 2 clks; digit 3 shows "1", digit 0 shows "4"; pos=0.
REQ-038 Scenario 2: start, dir=0, one_shot=0 -> pos steps 1,2,3,4,0,1 every 8 clks; leftmost digit shows "2" after the first tick.
REQ-039 Scenario 3: dir=1, one_shot=1, start at pos=0 -> pos sequence 4,3,2,1,0; done pulses on the tick to 0; busy falls in the same cycle.
REQ-040 Scenario 4: msg_len=2 with buffer {A,B} -> digits 3..0 show A,B,A,B; msg_len=0 -> seg=7'h7F on all digits.
REQ-041 Scenario 5: pos=4 in RUN, then msg_len written to 3 -> pos=0 the next cycle; start and stop in the same cycle from IDLE -> remains IDLE.
REQ-042 Scenario 6: rst pulsed mid-RUN at pos=3 -> pos=0, busy=0, no done pulse; the buffer still reads back 1,2,3,4,5 on the display.
